// File: rtl/chunked_adder_if.sv
// Operand/result bundle for chunked_adder: master drives operands, slave returns
// the combinational and registered sums.
interface chunked_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic [WIDTH-1:0] out_r;
  logic             cout_r;
  logic             out_valid;

  modport master (
    output a, b, in_valid,
    input  out, cout, out_r, cout_r, out_valid
  );

  modport slave (
    input  a, b, in_valid,
    output out, cout, out_r, cout_r, out_valid
  );
endinterface

// File: rtl/chunked_adder.sv
// Unsigned WIDTH-bit adder built from CHUNK-bit ripple stages, with a combinational
// sum and a one-cycle registered copy (sum, carry-out, valid).
module chunked_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  chunked_adder_if.slave         bus
);
  localparam int unsigned N = WIDTH / CHUNK;

  if ((CHUNK == 0) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
    $error("chunked_adder: CHUNK must evenly divide WIDTH");
  end

  logic [N:0]       carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_chunk
    logic [CHUNK:0] chunk_sum;
    // CHUNK+1-bit add; the top bit is the carry into the next chunk.
    assign chunk_sum = {1'b0, bus.a[i*CHUNK +: CHUNK]}
                     + {1'b0, bus.b[i*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, carry[i]};
    assign sum[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    assign carry[i+1]            = chunk_sum[CHUNK];
  end

  assign bus.out  = sum;
  assign bus.cout = carry[N];

  logic [WIDTH-1:0] out_q;
  logic             cout_q;
  logic             valid_q;

  // Loads every cycle; out_valid alone marks meaningful data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= sum;
      cout_q  <= carry[N];
      valid_q <= bus.in_valid;
    end
  end

  assign bus.out_r     = out_q;
  assign bus.cout_r    = cout_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: combinational sum, carry, registered path and
// synchronous reset behaviour against hand-computed vectors.
module tb_chunked_adder;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  chunked_adder_if #(.WIDTH(32)) bus ();

  chunked_adder #(
    .WIDTH(32),
    .CHUNK(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one operation, check the same-cycle result, then the registered copy.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic v, input logic [31:0] exp_sum, input logic exp_c);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = v;
    #1;
    check({tag, ".out"}, bus.out, exp_sum);
    check({tag, ".cout"}, {31'b0, bus.cout}, {31'b0, exp_c});
    @(posedge clk);
    #1;
    check({tag, ".out_r"}, bus.out_r, exp_sum);
    check({tag, ".cout_r"}, {31'b0, bus.cout_r}, {31'b0, exp_c});
    check({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, v});
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.a        = 32'd1;
    bus.b        = 32'd1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Registered path cleared in reset; combinational path still live.
    check("rst.out_r", bus.out_r, 32'd0);
    check("rst.cout_r", {31'b0, bus.cout_r}, 32'd0);
    check("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst.out", bus.out, 32'd2);
    @(negedge clk);
    rst_n = 1'b1;

    step("one_plus_one", 32'd1, 32'd1, 1'b1, 32'd2, 1'b0);
    step("cross_chunk", 32'd1234500000, 32'd67890, 1'b1, 32'd1234567890, 1'b0);
    step("max_plus_zero", 32'hFFFF_FFFF, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    step("near_max", 32'hFFFF_FFFA, 32'd5, 1'b1, 32'hFFFF_FFFF, 1'b0);
    step("comm_ab", 32'hFFFF_FFFA, 32'd4, 1'b1, 32'hFFFF_FFFE, 1'b0);
    step("comm_ba", 32'd4, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFFE, 1'b0);
    step("wrap_ripple", 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b1);
    step("wrap_msb", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'd0, 1'b1);
    step("chunk_carries", 32'h00FF_00FF, 32'h0001_0001, 1'b1, 32'h0100_0100, 1'b0);
    step("pattern", 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0);
    step("top_carry", 32'hF000_0001, 32'h1000_0002, 1'b1, 32'h0000_0003, 1'b1);

    // Mid-stream reset for one edge discards in-flight data.
    bus.a        = 32'd3;
    bus.b        = 32'd4;
    bus.in_valid = 1'b1;
    rst_n        = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst.out_r", bus.out_r, 32'd0);
    check("mid_rst.cout_r", {31'b0, bus.cout_r}, 32'd0);
    check("mid_rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst.out", bus.out, 32'd7);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("resume.out_r", bus.out_r, 32'd7);
    check("resume.out_valid", {31'b0, bus.out_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
